// File: rtl/rom_loader.sv
// rom_loader
//   Turns the HPS ioctl download stream into the dn_* ROM-upload bus used by
//   the system top. A combined image (file index 0) is split into the
//   pgrom/chrom/palrom/spriterom regions; files with index 1..3 go straight
//   to the matching region. The CPU is held in reset for the whole load plus
//   RESET_HOLD cycles, and ioctl_wait throttles the HPS after every
//   accepted byte.
//
// Optional feature: define ROM_LOADER_CHECKSUM_EN to build the additive
//   checksum of forwarded bytes. Without it, checksum is tied to 8'h00.
//
// Parameters
//   RESET_HOLD  cycles cpu_reset stays high after ioctl_download falls (>=1)
//   WR_GAP      cycles ioctl_wait stays high after each accepted write
//
// Ports
//   clk_sys         in   system clock
//   reset           in   asynchronous active-high reset
//   ioctl_download  in   HPS download in progress
//   ioctl_wr        in   one-cycle byte strobe
//   ioctl_addr      in   [24:0] byte address within the file
//   ioctl_dout      in   [7:0] byte data
//   ioctl_index     in   [7:0] file index
//   ioctl_wait      out  stall request to the HPS
//   dn_addr         out  [16:0] region-relative byte address
//   dn_data         out  [7:0] byte data
//   dn_wr           out  one-cycle write strobe
//   dn_index        out  [7:0] region: 0 pgrom, 1 chrom, 2 palrom, 3 spriterom
//   cpu_reset       out  CPU/system reset request
//   load_done       out  high from end of settle until the next download
//   drop_cnt        out  [15:0] discarded bytes, saturating
//   checksum        out  [7:0] additive checksum of forwarded bytes
//   state_dbg       out  [1:0] FSM state (0 IDLE, 1 LOAD, 2 SETTLE, 3 DONE)
//
// Handshake: a byte is taken when ioctl_wr=1 in a cycle where the FSM is in
// LOAD, ioctl_download=1 and ioctl_wait=0. Anything else on ioctl_wr is
// ignored and not counted. dn_wr is high for exactly the following cycle.
module rom_loader #(
  parameter int RESET_HOLD = 16,
  parameter int WR_GAP     = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [7:0]  dn_index,
  output logic        cpu_reset,
  output logic        load_done,
  output logic [15:0] drop_cnt,
  output logic [7:0]  checksum,
  output logic [1:0]  state_dbg
);

  localparam int HW = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD);
  localparam int GW = (WR_GAP < 2) ? 1 : $clog2(WR_GAP + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(WR_GAP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic          accept;
  logic          start_load;
  logic          hit;
  logic [7:0]    map_idx;
  logic [16:0]   map_addr;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (ioctl_download) state_n = S_LOAD;
      S_LOAD:   if (!ioctl_download) state_n = S_SETTLE;
      S_SETTLE: begin
        if (ioctl_download)            state_n = S_LOAD;
        else if (hold_cnt == HOLD_LAST) state_n = S_DONE;
      end
      S_DONE:   if (ioctl_download) state_n = S_LOAD;
      default:  state_n = S_IDLE;
    endcase
  end

  assign state_dbg  = state;
  assign cpu_reset  = (state != S_DONE);
  assign load_done  = (state == S_DONE);
  assign ioctl_wait = (state == S_LOAD) && (gap_cnt != '0);

  // A write coinciding with the falling edge of ioctl_download is dropped on
  // the floor because ioctl_download must still be high to accept.
  assign accept     = (state == S_LOAD) && ioctl_download && ioctl_wr && !ioctl_wait;
  assign start_load = ((state == S_IDLE) || (state == S_DONE)) && ioctl_download;

  // Address decode for the combined image and the per-region files.
  always_comb begin
    hit      = 1'b0;
    map_idx  = 8'd0;
    map_addr = 17'd0;
    case (ioctl_index)
      8'd0: begin
        if (ioctl_addr[24:15] == 10'd0) begin          // 0x00000-0x07FFF
          hit      = 1'b1;
          map_idx  = 8'd0;
          map_addr = ioctl_addr[16:0];
        end else if (ioctl_addr[24:11] == 14'h0010) begin // 0x08000-0x087FF
          hit      = 1'b1;
          map_idx  = 8'd1;
          map_addr = {6'd0, ioctl_addr[10:0]};
        end else if (ioctl_addr[24:5] == 20'h00800) begin // 0x10000-0x1001F
          hit      = 1'b1;
          map_idx  = 8'd2;
          map_addr = {12'd0, ioctl_addr[4:0]};
        end else if (ioctl_addr[24:11] == 14'h0022) begin // 0x11000-0x117FF
          hit      = 1'b1;
          map_idx  = 8'd3;
          map_addr = {6'd0, ioctl_addr[10:0]};
        end
      end
      8'd1, 8'd2, 8'd3: begin
        if (ioctl_addr[24:17] == 8'd0) begin
          hit      = 1'b1;
          map_idx  = ioctl_index;
          map_addr = ioctl_addr[16:0];
        end
      end
      default: hit = 1'b0;
    endcase
  end

  // Hold counter only runs while staying in SETTLE; any exit clears it.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                                        hold_cnt <= '0;
    else if ((state == S_SETTLE) && (state_n == S_SETTLE)) hold_cnt <= hold_cnt + 1'b1;
    else                                              hold_cnt <= '0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                 gap_cnt <= '0;
    else if (state != S_LOAD)  gap_cnt <= '0;
    else if (accept)           gap_cnt <= GAP_LOAD;
    else if (gap_cnt != '0)    gap_cnt <= gap_cnt - 1'b1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dn_wr    <= 1'b0;
      dn_addr  <= 17'd0;
      dn_data  <= 8'd0;
      dn_index <= 8'd0;
    end else begin
      dn_wr <= accept && hit;
      if (accept && hit) begin
        dn_addr  <= map_addr;
        dn_data  <= ioctl_dout;
        dn_index <= map_idx;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                                      drop_cnt <= 16'd0;
    else if (start_load)                            drop_cnt <= 16'd0;
    else if (accept && !hit && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)           sum_q <= 8'd0;
    else if (start_load) sum_q <= 8'd0;
    else if (dn_wr)      sum_q <= sum_q + dn_data;
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wait;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [7:0]  dn_index;
  logic        cpu_reset;
  logic        load_done;
  logic [15:0] drop_cnt;
  logic [7:0]  checksum;
  logic [1:0]  state_dbg;

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  rom_loader #(.RESET_HOLD(16), .WR_GAP(2)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .dn_addr(dn_addr),
    .dn_data(dn_data), .dn_wr(dn_wr), .dn_index(dn_index), .cpu_reset(cpu_reset),
    .load_done(load_done), .drop_cnt(drop_cnt), .checksum(checksum),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          tests = 0;
  int          fails = 0;
  logic [32:0] exp_q[$];   // {dn_index, dn_addr, dn_data}
  int          exp_drop = 0;
  logic [7:0]  exp_sum = 8'd0;
  logic [16:0] last_addr = '0;
  logic [7:0]  last_idx = '0;
  logic [7:0]  last_data = '0;

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  data;
    logic        hit;
    logic [7:0]  eidx;
    logic [16:0] eaddr;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    if (dn_wr === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL dn_wr_unexpected: got idx=%0h addr=%0h data=%0h expected no write",
                 dn_index, dn_addr, dn_data);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({dn_index, dn_addr, dn_data} !== e) begin
          fails++;
          $display("FAIL dn_write: got idx=%0h addr=%0h data=%0h expected idx=%0h addr=%0h data=%0h",
                   dn_index, dn_addr, dn_data, e[32:25], e[24:8], e[7:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (ioctl_wait !== 1'b0 && g < 20) begin
      tick();
      g++;
    end
    if (g >= 20) check("wait_ready_timeout", 32'(ioctl_wait), 32'd0);
  endtask

  task automatic send(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data,
                      input logic hit, input logic [7:0] eidx, input logic [16:0] eaddr);
    wait_ready();
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = data;
    ioctl_wr    = 1'b1;
    if (hit) begin
      exp_q.push_back({eidx, eaddr, data});
      last_idx  = eidx;
      last_addr = eaddr;
      last_data = data;
      exp_sum   = exp_sum + data;
    end else begin
      exp_drop++;
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_from_idle_or_done();
    ioctl_download = 1'b1;
    exp_drop = 0;
    exp_sum  = 8'd0;
    tick();
  endtask

  initial begin
    vecs[0]  = '{8'd0,   25'h00005, 8'hAA, 1'b1, 8'd0, 17'h00005};
    vecs[1]  = '{8'd0,   25'h08010, 8'h55, 1'b1, 8'd1, 17'h00010};
    vecs[2]  = '{8'd0,   25'h09000, 8'h11, 1'b0, 8'd0, 17'h0};
    vecs[3]  = '{8'd0,   25'h10020, 8'h12, 1'b0, 8'd0, 17'h0};
    vecs[4]  = '{8'd0,   25'h1001F, 8'h13, 1'b1, 8'd2, 17'h0001F};
    vecs[5]  = '{8'd0,   25'h07FFF, 8'h14, 1'b1, 8'd0, 17'h07FFF};
    vecs[6]  = '{8'd0,   25'h087FF, 8'h15, 1'b1, 8'd1, 17'h007FF};
    vecs[7]  = '{8'd0,   25'h08800, 8'h16, 1'b0, 8'd0, 17'h0};
    vecs[8]  = '{8'd0,   25'h10000, 8'h17, 1'b1, 8'd2, 17'h00000};
    vecs[9]  = '{8'd0,   25'h11000, 8'h18, 1'b1, 8'd3, 17'h00000};
    vecs[10] = '{8'd0,   25'h117FF, 8'h19, 1'b1, 8'd3, 17'h007FF};
    vecs[11] = '{8'd0,   25'h11800, 8'h1A, 1'b0, 8'd0, 17'h0};
    vecs[12] = '{8'd0,   25'h20000, 8'h1B, 1'b0, 8'd0, 17'h0};
    vecs[13] = '{8'd1,   25'h1ABCD, 8'h1C, 1'b1, 8'd1, 17'h1ABCD};
    vecs[14] = '{8'd3,   25'h00042, 8'h1D, 1'b1, 8'd3, 17'h00042};
    vecs[15] = '{8'd2,   25'h20000, 8'h1E, 1'b0, 8'd0, 17'h0};
    vecs[16] = '{8'd4,   25'h00000, 8'h1F, 1'b0, 8'd0, 17'h0};

    // reset values
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    tick();
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
    check("rst_dn_wr", 32'(dn_wr), 32'd0);
    check("rst_dn_addr", 32'(dn_addr), 32'd0);
    check("rst_dn_data", 32'(dn_data), 32'd0);
    check("rst_dn_index", 32'(dn_index), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // strobe outside LOAD is ignored
    ioctl_addr = 25'h00001;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    check("idle_wr_drop_cnt", 32'(drop_cnt), 32'd0);

    // table of decode vectors
    start_from_idle_or_done();
    check("load_state", 32'(state_dbg), 32'd1);
    check("load_cpu_reset", 32'(cpu_reset), 32'd1);
    for (int i = 0; i < 17; i++) begin
      send(vecs[i].idx, vecs[i].addr, vecs[i].data, vecs[i].hit, vecs[i].eidx, vecs[i].eaddr);
      check($sformatf("vec%0d_dn_wr", i), 32'(dn_wr), 32'(vecs[i].hit));
      check($sformatf("vec%0d_dn_addr", i), 32'(dn_addr), 32'(last_addr));
      check($sformatf("vec%0d_dn_index", i), 32'(dn_index), 32'(last_idx));
      check($sformatf("vec%0d_dn_data", i), 32'(dn_data), 32'(last_data));
    end
    tick();
    tick();
    check("table_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    check("table_checksum", 32'(checksum), CK_EN ? 32'(exp_sum) : 32'd0);

    // pacing: wait for two cycles after an accepted write, strobe during wait ignored
    wait_ready();
    ioctl_index = 8'd0;
    ioctl_addr  = 25'h00100;
    ioctl_dout  = 8'h3C;
    ioctl_wr    = 1'b1;
    exp_q.push_back({8'd0, 17'h00100, 8'h3C});
    exp_sum = exp_sum + 8'h3C;
    tick();
    check("pace_wait_t1", 32'(ioctl_wait), 32'd1);
    ioctl_addr = 25'h09000;
    tick();
    check("pace_wait_t2", 32'(ioctl_wait), 32'd1);
    ioctl_wr = 1'b0;
    tick();
    check("pace_wait_t3", 32'(ioctl_wait), 32'd0);
    check("pace_drop_cnt", 32'(drop_cnt), 32'(exp_drop));

    // write on the falling edge of ioctl_download is ignored
    ioctl_download = 1'b0;
    ioctl_addr = 25'h00010;
    ioctl_dout = 8'h77;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    check("fall_state_settle", 32'(state_dbg), 32'd2);
    check("fall_dn_wr", 32'(dn_wr), 32'd0);

    // re-raise after 8 settle cycles: back to LOAD, counts preserved
    repeat (7) tick();
    check("settle8_cpu_reset", 32'(cpu_reset), 32'd1);
    ioctl_download = 1'b1;
    tick();
    check("reraise_state", 32'(state_dbg), 32'd1);
    check("reraise_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reraise_drop_kept", 32'(drop_cnt), 32'(exp_drop));

    // full settle: 16 cycles after download falls
    ioctl_download = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 1)  check("settle_enter", 32'(state_dbg), 32'd2);
      if (i == 16) begin
        check("settle16_cpu_reset", 32'(cpu_reset), 32'd1);
        check("settle16_load_done", 32'(load_done), 32'd0);
      end
      if (i == 17) begin
        check("done_cpu_reset", 32'(cpu_reset), 32'd0);
        check("done_load_done", 32'(load_done), 32'd1);
        check("done_state", 32'(state_dbg), 32'd3);
      end
    end

    // strobe in DONE is ignored
    ioctl_addr = 25'h09000;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    check("done_wr_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    check("done_wait", 32'(ioctl_wait), 32'd0);

    // new download from DONE clears counters, checksum of 0xF0 + 0x20
    start_from_idle_or_done();
    check("reload_drop_clr", 32'(drop_cnt), 32'd0);
    check("reload_sum_clr", 32'(checksum), 32'd0);
    check("reload_load_done", 32'(load_done), 32'd0);
    send(8'd0, 25'h00200, 8'hF0, 1'b1, 8'd0, 17'h00200);
    send(8'd0, 25'h00201, 8'h20, 1'b1, 8'd0, 17'h00201);
    tick();
    tick();
    tick();
    check("checksum_f0_20", 32'(checksum), CK_EN ? 32'h10 : 32'd0);

    // one dropped byte, then reset in the middle of the load
    send(8'd0, 25'h09001, 8'h01, 1'b0, 8'd0, 17'h0);
    tick();
    check("preabort_drop_cnt", 32'(drop_cnt), 32'd1);
    check("preabort_wait", 32'(ioctl_wait), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_wait", 32'(ioctl_wait), 32'd0);
    check("abort_dn_addr", 32'(dn_addr), 32'd0);
    check("abort_dn_data", 32'(dn_data), 32'd0);
    check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    check("abort_drop_cnt", 32'(drop_cnt), 32'd0);
    check("abort_checksum", 32'(checksum), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("after_abort_idle", 32'(state_dbg), 32'd0);

    // restart from IDLE after abort
    last_addr = '0;
    last_idx  = '0;
    last_data = '0;
    start_from_idle_or_done();
    send(8'd2, 25'h00007, 8'h99, 1'b1, 8'd2, 17'h00007);
    check("restart_dn_addr", 32'(dn_addr), 32'h7);
    tick();
    tick();
    tick();
    check("restart_checksum", 32'(checksum), CK_EN ? 32'h99 : 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
